// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory over a byte link,
// verifies an XOR checksum, then releases the core from reset.
module imem_boot_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_n;
    logic [1:0]        r_bcnt;
    logic [7:0]        r_csum;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_core_reset;
    logic              r_done;
    logic              r_error;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_cnt_ok;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                      (r_state == S_CHECK);
    assign w_accept = rx_valid & w_ready;
    assign w_last   = (CNT_W'(r_addr) == (r_n - CNT_W'(1)));
    assign w_cnt_ok = (rx_data != 8'd0) && (int'(rx_data) <= DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_bcnt       <= '0;
            r_csum       <= '0;
            r_wdata      <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_cnt_ok) begin
                            r_n     <= CNT_W'(rx_data);
                            r_state <= S_LOAD;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_csum  <= r_csum ^ rx_data;
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // address only advances once the write has been issued
                    if (w_last) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (rx_data == r_csum) begin
                            r_core_reset <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_RUN;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_RUN: ;
                S_ERR: ;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign rx_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with an imem write model.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int tests;
    int fails;

    logic [31:0] mem [64];
    int          wr_cnt;
    int          last_addr;
    int          bad_ready;
    int          bad_both;

    imem_boot_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            wr_cnt         = wr_cnt + 1;
            last_addr      = int'(imem_addr);
            if (rx_ready) bad_ready = bad_ready + 1;
        end
        if (done && error) bad_both = bad_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests = tests + 1;
        if (obs !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
        wr_cnt    = 0;
        last_addr = -1;
        bad_ready = 0;
        bad_both  = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  {31'd0, rx_ready},   32'd1);
        check({tag, "_we"},   {31'd0, imem_we},    32'd0);
        check({tag, "_addr"}, {26'd0, imem_addr},  32'd0);
        check({tag, "_wd"},   imem_wdata,          32'd0);
        check({tag, "_crst"}, {31'd0, core_reset}, 32'd1);
        check({tag, "_done"}, {31'd0, done},       32'd0);
        check({tag, "_err"},  {31'd0, error},      32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // present a byte, wait for rx_ready, and return 1 ns after the accepting edge
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
    endtask

    task automatic run_good(input string tag, input int gap);
        logic [7:0] s [10];
        s = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05,
              8'h20, 8'h03, 8'h00, 8'h0C, 8'h08};
        for (int i = 0; i < 9; i++) send(s[i], gap);
        repeat (2) @(negedge clk);
        check({tag, "_crst_pre"}, {31'd0, core_reset}, 32'd1);
        send(s[9], gap);
        check({tag, "_crst"}, {31'd0, core_reset}, 32'd0);
        check({tag, "_done"}, {31'd0, done},       32'd1);
        check({tag, "_err"},  {31'd0, error},      32'd0);
        check({tag, "_m0"},   mem[0],              32'h20020005);
        check({tag, "_m1"},   mem[1],              32'h2003000C);
        check({tag, "_wr"},   wr_cnt,              32'd2);
        check({tag, "_addr"}, {26'd0, imem_addr},  32'd1);
        @(negedge clk);
        check({tag, "_rdy_run"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_rdy_we"},  bad_ready,         32'd0);
    endtask

    initial begin
        logic [7:0] bad [10];
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear_model();
        #1;
        check_reset_vals("rst0");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // test 1
        run_good("t1", 0);

        // test 2: bad checksum
        do_reset();
        bad = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05,
                8'h20, 8'h03, 8'h00, 8'h0C, 8'h09};
        for (int i = 0; i < 10; i++) send(bad[i], 0);
        check("t2_err",  {31'd0, error},      32'd1);
        check("t2_done", {31'd0, done},       32'd0);
        check("t2_crst", {31'd0, core_reset}, 32'd1);
        check("t2_wr",   wr_cnt,              32'd2);
        check("t2_rdy",  {31'd0, rx_ready},   32'd0);

        // test 3: illegal counts
        do_reset();
        send(8'h00, 0);
        check("t3a_err",  {31'd0, error},      32'd1);
        check("t3a_done", {31'd0, done},       32'd0);
        check("t3a_rdy",  {31'd0, rx_ready},   32'd0);
        repeat (3) @(negedge clk);
        check("t3a_wr",   wr_cnt,              32'd0);
        do_reset();
        send(8'h41, 0);
        check("t3b_err",  {31'd0, error},      32'd1);
        check("t3b_crst", {31'd0, core_reset}, 32'd1);
        repeat (3) @(negedge clk);
        check("t3b_wr",   wr_cnt,              32'd0);
        do_reset();
        send(8'h40, 0);
        check("t3c_err",  {31'd0, error},      32'd0);

        // test 4: stalls between bytes
        do_reset();
        run_good("t4", 3);

        // test 5: reset mid-load, then replay
        do_reset();
        send(8'h02, 0);
        send(8'h20, 0);
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h05, 0);
        send(8'h20, 0);
        check("t5_wr_pre", wr_cnt, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("t5rst");
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        run_good("t5", 0);

        // test 6: full depth, word k = k
        do_reset();
        send(8'h40, 0);
        for (int k = 0; k < 64; k++) begin
            send(8'h00, 0);
            send(8'h00, 0);
            send(8'h00, 0);
            send(8'(k), 0);
        end
        send(8'h00, 0);
        check("t6_done", {31'd0, done},      32'd1);
        check("t6_err",  {31'd0, error},     32'd0);
        check("t6_wr",   wr_cnt,             32'd64);
        check("t6_last", last_addr,          32'h3F);
        check("t6_addr", {26'd0, imem_addr}, 32'h3F);
        check("t6_m0",   mem[0],             32'd0);
        check("t6_m1e",  mem[30],            32'd30);
        check("t6_m3f",  mem[63],            32'd63);
        check("t6_rdy_we", bad_ready,        32'd0);
        check("both_flags", bad_both,        32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
